lift_scheduler: RTL



---
 rtl/lift_scheduler_if.sv | 42 ++++
 rtl/lift_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lift_scheduler_if.sv
// lift_scheduler_if
//   Bundles the signals between the lift scheduler and its neighbours
//   (call-button logic, door controller, floor indicator).
//
//   Door handshake: the scheduler raises door_req for exactly one cycle to
//   ask for a door open, or to extend an open door. The door controller
//   reports the physical door through door_open, which is a level. The
//   scheduler considers the cycle finished when it has seen door_open rise
//   and then fall. call_req is a level per floor. Any cycle it is high
//   latches a call.
//
//   Modports
//     master : the scheduler (drives status and door_req)
//     slave  : the environment (drives call_req and door_open)
//   state_dbg exposes the scheduler FSM state for observation.
interface lift_scheduler_if #(
    parameter int N_FLOORS = 12,
    parameter int FLOOR_W  = 4
);
    logic [N_FLOORS-1:0] call_req;
    logic                door_open;
    logic                door_req;
    logic [FLOOR_W-1:0]  current_floor;
    logic                moving_up;
    logic                moving_down;
    logic [N_FLOORS-1:0] pending;
    logic                idle;
    logic                fault;
    logic [2:0]          state_dbg;

    modport master (
        input  call_req, door_open,
        output door_req, current_floor, moving_up, moving_down,
               pending, idle, fault, state_dbg
    );

    modport slave (
        output call_req, door_open,
        input  door_req, current_floor, moving_up, moving_down,
               pending, idle, fault, state_dbg
    );
endinterface

// File: rtl/lift_scheduler.sv
// lift_scheduler
//   Car-motion scheduler. It latches floor calls and chooses the travel
//   direction with a SCAN policy: the car keeps going while calls lie ahead
//   and reverses otherwise. It times floor-to-floor travel. On arrival it
//   pulses door_req and holds the car until the door has opened and closed.
//
//   Ports
//     clk      : system clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : lift_scheduler_if.master. It carries call_req and door_open
//                in, and door_req, current_floor, moving_up, moving_down,
//                pending, idle, fault and state_dbg out.
//
//   Optional feature macro: LIFT_DOOR_WATCHDOG_EN
//     When this macro is defined, a watchdog runs in DOOR_WAIT. If door_open
//     has not risen DOOR_ACK_TIMEOUT cycles after door_req, the watchdog
//     sets a sticky fault and parks the car in IDLE.
//     When it is undefined, fault is constant 0.
module lift_scheduler #(
    parameter int N_FLOORS            = 12,
    parameter int FLOOR_W             = 4,
    parameter int FLOOR_TRAVEL_CYCLES = 100,
    parameter int DOOR_ACK_TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    lift_scheduler_if.master bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MOVE      = 3'd1;
    localparam logic [2:0] S_ARRIVE    = 3'd2;
    localparam logic [2:0] S_DOOR_WAIT = 3'd3;
    localparam logic [2:0] S_DOOR_HOLD = 3'd4;

    localparam int TRAVEL_W = (FLOOR_TRAVEL_CYCLES > 1) ? $clog2(FLOOR_TRAVEL_CYCLES) : 1;
    localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(FLOOR_TRAVEL_CYCLES - 1);
    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

    // Floor indexing goes through these helpers so that FLOOR_W may be wider
    // than the pending vector needs.
    function automatic logic bit_at(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) == f) r = v[i];
        return r;
    endfunction

    function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) > f && v[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) < f && v[i]) r = 1'b1;
        return r;
    endfunction

    logic [2:0]          state_q, state_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [TRAVEL_W-1:0] cnt_q, cnt_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [N_FLOORS-1:0] call_prev_q, call_prev_d;
    logic                dir_up_q, dir_up_d;
    logic                door_req_q, door_req_d;
    logic                fault_now;

    logic [N_FLOORS-1:0] cur_mask;
    logic [FLOOR_W-1:0]  next_floor;
    logic                in_door, absorb, ahead_fwd, ahead_rev, at_limit;

`ifdef LIFT_DOOR_WATCHDOG_EN
    localparam int WD_W = $clog2(DOOR_ACK_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            fault_q, fault_d;
    assign fault_now = fault_q;
`else
    assign fault_now = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        cnt_d       = cnt_q;
        dir_up_d    = dir_up_q;
        call_prev_d = bus.call_req;
`ifdef LIFT_DOOR_WATCHDOG_EN
        wd_cnt_d = wd_cnt_q;
        fault_d  = fault_q;
`endif
        cur_mask = '0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) == floor_q) cur_mask[i] = 1'b1;

        // While the car stands at a floor with the door cycle running, a
        // call for that floor is consumed rather than latched. A fresh press
        // (rising edge) re-pulses door_req so the door controller restarts
        // its hold.
        in_door   = (state_q == S_ARRIVE) || (state_q == S_DOOR_WAIT) || (state_q == S_DOOR_HOLD);
        absorb    = ((state_q == S_DOOR_WAIT) || (state_q == S_DOOR_HOLD)) &&
                    bit_at(bus.call_req & ~call_prev_q, floor_q);
        pending_d = (pending_q | bus.call_req) & ~(in_door ? cur_mask : '0);

        ahead_fwd  = dir_up_q ? any_above(pending_q, floor_q) : any_below(pending_q, floor_q);
        ahead_rev  = dir_up_q ? any_below(pending_q, floor_q) : any_above(pending_q, floor_q);
        at_limit   = dir_up_q ? (floor_q == TOP_FLOOR) : (floor_q == '0);
        next_floor = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!bus.door_open && !fault_now) begin
                    if (bit_at(pending_q, floor_q)) begin
                        state_d = S_ARRIVE;
                    end else if (ahead_fwd) begin
                        state_d = S_MOVE;
                    end else if (ahead_rev) begin
                        dir_up_d = ~dir_up_q;
                        state_d  = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d = '0;
                    if (at_limit) begin
                        state_d = S_IDLE;
                    end else begin
                        floor_d = next_floor;
                        if (bit_at(pending_q, next_floor))
                            state_d = S_ARRIVE;
                        else if (!(dir_up_q ? any_above(pending_q, next_floor)
                                            : any_below(pending_q, next_floor)))
                            state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + TRAVEL_W'(1);
                end
            end
            S_ARRIVE: begin
                state_d = S_DOOR_WAIT;
`ifdef LIFT_DOOR_WATCHDOG_EN
                // The ARRIVE cycle is the door_req cycle, so the first
                // DOOR_WAIT cycle is already one cycle after the request.
                wd_cnt_d = WD_W'(1);
`endif
            end
            S_DOOR_WAIT: begin
                if (bus.door_open) begin
                    state_d = S_DOOR_HOLD;
`ifdef LIFT_DOOR_WATCHDOG_EN
                end else if (wd_cnt_q >= WD_W'(DOOR_ACK_TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
`endif
                end
            end
            S_DOOR_HOLD: begin
                if (!bus.door_open) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        door_req_d = (state_d == S_ARRIVE) || absorb;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            floor_q     <= '0;
            cnt_q       <= '0;
            pending_q   <= '0;
            call_prev_q <= '0;
            dir_up_q    <= 1'b1;
            door_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            call_prev_q <= call_prev_d;
            dir_up_q    <= dir_up_d;
            door_req_q  <= door_req_d;
        end
    end

`ifdef LIFT_DOOR_WATCHDOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            fault_q  <= fault_d;
        end
    end
`endif

    assign bus.door_req      = door_req_q;
    assign bus.current_floor = floor_q;
    assign bus.moving_up     = (state_q == S_MOVE) && dir_up_q;
    assign bus.moving_down   = (state_q == S_MOVE) && !dir_up_q;
    assign bus.pending       = pending_q;
    assign bus.idle          = (state_q == S_IDLE);
    assign bus.fault         = fault_now;
    assign bus.state_dbg     = state_q;
endmodule
